// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU function codes, datapath defaults and forwarding select encoding
package alu_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam int REGW_DEFAULT = 5;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    typedef enum logic [1:0] {FWD_RF, FWD_EXMEM, FWD_MEMWB} fwd_sel_e;
endpackage

// File: rtl/forwarding_unit.sv
// forwarding_unit: picks the newest in-flight value for one source register
module forwarding_unit
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int REGW = REGW_DEFAULT
) (
    input  logic [REGW-1:0] rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic            exmem_reg_write,
    input  logic [REGW-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [REGW-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_data,
    output logic [XLEN-1:0] data
);
    fwd_sel_e sel;
    // EX/MEM is younger than MEM/WB so it wins; x0 never matches
    always_comb begin
        sel  = (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs) ? FWD_EXMEM :
               (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs) ? FWD_MEMWB : FWD_RF;
        data = (sel == FWD_EXMEM) ? exmem_result : (sel == FWD_MEMWB) ? memwb_data : rf_data;
    end
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with operand forwarding, load-use detection and bubbles
module id_ex_operand_stage
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int REGW = REGW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_alu_src,
    input  logic [2:0]      id_alu_f,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            hold,
    input  logic            flush,
    input  logic            exmem_reg_write,
    input  logic [REGW-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [REGW-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_data,
    output logic [XLEN-1:0] oporand1,
    output logic [XLEN-1:0] oporand2,
    output logic [2:0]      f,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [REGW-1:0] ex_rd,
    output logic [XLEN-1:0] ex_store_data,
    output logic            load_use_stall
);
    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            alu_src;
        logic [2:0]      alu_f;
        logic [REGW-1:0] rd;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
    } stage_t;

    stage_t          stage_q, stage_d;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;
    logic            uses_rs2;

    // A load in EX whose result ID needs next cycle cannot be forwarded in time
    always_comb begin
        uses_rs2       = !id_alu_src || id_mem_write;
        load_use_stall = !hold && !flush && id_valid && stage_q.valid && stage_q.mem_read &&
                         stage_q.rd != '0 &&
                         (stage_q.rd == id_rs1 || (uses_rs2 && stage_q.rd == id_rs2));
    end

    // Next register contents: flush > hold > stall bubble > capture from decode
    always_comb begin
        stage_d = stage_q;
        if (flush || (!hold && load_use_stall)) begin
            stage_d = '0;
        end else if (!hold) begin
            stage_d.valid     = id_valid;
            stage_d.reg_write = id_reg_write & id_valid;
            stage_d.mem_read  = id_mem_read & id_valid;
            stage_d.mem_write = id_mem_write & id_valid;
            stage_d.alu_src   = id_alu_src;
            stage_d.alu_f     = id_alu_f;
            stage_d.rd        = id_rd;
            stage_d.rs1       = id_rs1;
            stage_d.rs2       = id_rs2;
            stage_d.rs1_data  = id_rs1_data;
            stage_d.rs2_data  = id_rs2_data;
            stage_d.imm       = id_imm;
        end
    end

    // Stage register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) stage_q <= '0;
        else     stage_q <= stage_d;
    end

    forwarding_unit #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs1 (
        .rs(stage_q.rs1), .rf_data(stage_q.rs1_data),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .data(fwd_rs1)
    );

    forwarding_unit #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs2 (
        .rs(stage_q.rs2), .rf_data(stage_q.rs2_data),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .data(fwd_rs2)
    );

    assign oporand1      = fwd_rs1;
    assign oporand2      = stage_q.alu_src ? stage_q.imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign f             = stage_q.alu_f;
    assign ex_valid      = stage_q.valid;
    assign ex_reg_write  = stage_q.reg_write;
    assign ex_mem_read   = stage_q.mem_read;
    assign ex_mem_write  = stage_q.mem_write;
    assign ex_rd         = stage_q.rd;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: random and directed checks against a behavioural pipeline-slot model
module tb_id_ex_operand_stage;
    logic        clk = 0;
    logic        rst, id_valid, id_alu_src, id_reg_write, id_mem_read, id_mem_write, hold, flush;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, exmem_result, memwb_data;
    logic [4:0]  id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd;
    logic [2:0]  id_alu_f;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] oporand1, oporand2, ex_store_data;
    logic [2:0]  f;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;
    logic [4:0]  ex_rd;

    int n_chk = 0;
    int n_pass = 0;

    logic        m_valid, m_rw, m_mr, m_mw, m_src;
    logic [2:0]  m_f;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [31:0] m_d1, m_d2, m_imm;

    id_ex_operand_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_src(id_alu_src), .id_alu_f(id_alu_f),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .hold(hold), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .oporand1(oporand1), .oporand2(oporand2), .f(f),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
        .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
        if (exmem_reg_write && exmem_rd != 0 && exmem_rd == rs) return exmem_result;
        if (memwb_reg_write && memwb_rd != 0 && memwb_rd == rs) return memwb_data;
        return rf;
    endfunction

    function automatic logic stall_exp();
        if (hold || flush || !id_valid || !m_valid || !m_mr || m_rd == 0) return 1'b0;
        return (m_rd == id_rs1) || (m_rd == id_rs2 && (!id_alu_src || id_mem_write));
    endfunction

    task automatic model_clear();
        {m_valid, m_rw, m_mr, m_mw, m_src, m_f, m_rd, m_rs1, m_rs2, m_d1, m_d2, m_imm} = '0;
    endtask

    task automatic set_idle();
        {id_valid, id_alu_src, id_reg_write, id_mem_read, id_mem_write, hold, flush} = '0;
        {id_rs1_data, id_rs2_data, id_imm, exmem_result, memwb_data} = '0;
        {id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd, id_alu_f} = '0;
        {exmem_reg_write, memwb_reg_write} = '0;
    endtask

    task automatic randomize_inputs();
        rst             = ($urandom_range(0, 39) == 0);
        flush           = ($urandom_range(0, 7) == 0);
        hold            = ($urandom_range(0, 5) == 0);
        id_valid        = ($urandom_range(0, 4) != 0);
        id_alu_src      = $urandom_range(0, 1);
        id_reg_write    = $urandom_range(0, 1);
        id_mem_read     = ($urandom_range(0, 2) == 0);
        id_mem_write    = ($urandom_range(0, 3) == 0);
        id_alu_f        = $urandom_range(0, 7);
        id_rs1          = $urandom_range(0, 5);
        id_rs2          = $urandom_range(0, 5);
        id_rd           = $urandom_range(0, 5);
        id_rs1_data     = $urandom;
        id_rs2_data     = $urandom;
        id_imm          = $urandom;
        exmem_reg_write = $urandom_range(0, 1);
        memwb_reg_write = $urandom_range(0, 1);
        exmem_rd        = $urandom_range(0, 5);
        memwb_rd        = $urandom_range(0, 5);
        exmem_result    = $urandom;
        memwb_data      = $urandom;
    endtask

    // Compare every output against the model, then advance model and DUT one clock
    task automatic tick();
        logic s;
        #1;
        s = stall_exp();
        check("op1", oporand1, fwd(m_rs1, m_d1));
        check("op2", oporand2, m_src ? m_imm : fwd(m_rs2, m_d2));
        check("store", ex_store_data, fwd(m_rs2, m_d2));
        check("f", {29'b0, f}, {29'b0, m_f});
        check("rd", {27'b0, ex_rd}, {27'b0, m_rd});
        check("ctl", {28'b0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write},
              {28'b0, m_valid, m_rw, m_mr, m_mw});
        check("stall", {31'b0, load_use_stall}, {31'b0, s});
        if (rst || flush || (!hold && s)) model_clear();
        else if (!hold) begin
            m_valid = id_valid;
            m_rw = id_reg_write && id_valid;
            m_mr = id_mem_read && id_valid;
            m_mw = id_mem_write && id_valid;
            m_src = id_alu_src; m_f = id_alu_f; m_rd = id_rd; m_rs1 = id_rs1; m_rs2 = id_rs2;
            m_d1 = id_rs1_data; m_d2 = id_rs2_data; m_imm = id_imm;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        set_idle();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        model_clear();
        tick();
        #1;
        check("rst_valid", {31'b0, ex_valid}, 32'd0);
        check("rst_f", {29'b0, f}, 32'd0);
        rst = 0;

        id_valid = 1; id_rs1_data = 5; id_rs2_data = 3; id_alu_f = 3'b001;
        id_rs1 = 1; id_rs2 = 2; id_rd = 3; id_reg_write = 1;
        tick();
        set_idle();
        #1;
        check("tp_op1", oporand1, 32'd5);
        check("tp_op2", oporand2, 32'd3);
        check("tp_f", {29'b0, f}, 32'd1);
        check("tp_valid", {31'b0, ex_valid}, 32'd1);
        tick();

        id_valid = 1; id_rs1 = 7; id_rs1_data = 32'h11; id_rd = 2;
        tick();
        set_idle();
        hold = 1;
        exmem_reg_write = 1; exmem_rd = 7; exmem_result = 32'hAA;
        memwb_reg_write = 1; memwb_rd = 7; memwb_data = 32'hBB;
        #1 check("fwd_exmem", oporand1, 32'hAA);
        tick();
        exmem_reg_write = 0;
        #1 check("fwd_memwb", oporand1, 32'hBB);
        tick();
        exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
        #1 check("fwd_rf", oporand1, 32'h11);
        tick();
        set_idle();

        id_valid = 1; id_alu_src = 1; id_imm = 32'hFFFF_FFFC; id_rs2 = 5; id_rs2_data = 1;
        tick();
        set_idle();
        exmem_reg_write = 1; exmem_rd = 5; exmem_result = 9;
        #1;
        check("imm_op2", oporand2, 32'hFFFF_FFFC);
        check("imm_store", ex_store_data, 32'd9);
        tick();
        set_idle();

        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 4; id_rs1 = 1;
        tick();
        set_idle();
        id_valid = 1; id_rs1 = 1; id_rs2 = 4; id_alu_src = 0;
        #1 check("lu_stall", {31'b0, load_use_stall}, 32'd1);
        tick();
        #1;
        check("lu_bubble", {30'b0, ex_valid, ex_reg_write}, 32'd0);
        check("lu_clear", {31'b0, load_use_stall}, 32'd0);
        tick();
        set_idle();

        id_valid = 1; id_rs1 = 3; id_rs1_data = 32'h1234_5678; id_reg_write = 1; id_rd = 6;
        tick();
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            id_rs1_data = $urandom; id_rs1 = $urandom_range(0, 5);
            tick();
            #1 check("hold_op1", oporand1, 32'h1234_5678);
        end
        flush = 1;
        tick();
        #1 check("flush_hold", {oporand1[30:0], ex_valid}, 32'd0);
        flush = 0; hold = 0;
        id_valid = 1; id_rs1 = 3; id_rs1_data = 32'h55; id_reg_write = 1;
        tick();
        hold = 1; rst = 1;
        tick();
        #1 check("rst_hold", {oporand1[27:0], ex_valid, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
        rst = 0;
        set_idle();

        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline register and operand-delivery stage sitting directly upstream of the 32-bit ALU in the pipelined core. Captures decoded operands and control from the decode stage each cycle, then drives the ALU's two operands and 3-bit function code. Operands are forwarded from EX/MEM and MEM/WB. A load-use stall request is generated, and bubble insertion is handled on hold and flush.

## Interface
- XLEN, 32, datapath width
- REGW, 5, register index width
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous and active-high
- id_valid  in  1  decode stage holds a real instruction
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  REGW  register indices
- id_alu_src  in  1  1 = operand2 from immediate
- id_alu_f  in  3  ALU function code
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- hold  in  1  freeze the stage (downstream memory busy)
- flush  in  1  kill the instruction entering EX (branch taken)
- exmem_reg_write  in  1  EX/MEM writes a register
- exmem_rd  in  REGW  EX/MEM destination
- exmem_result  in  XLEN  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB writes a register
- memwb_rd  in  REGW  MEM/WB destination
- memwb_data  in  XLEN  MEM/WB write-back value
- oporand1, oporand2  out  XLEN  ALU operands
- f  out  3  ALU function code
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control, gated by valid
- ex_rd  out  REGW  registered destination
- ex_store_data  out  XLEN  forwarded rs2 value, used for stores
- load_use_stall  out  1  request to freeze PC and IF/ID this cycle

## Operation
- Register update priority per clock edge is rst > flush > hold > load_use_stall > normal load.
- rst: all registered fields go to 0, including ex_valid and the control bits. f resets to 000.
- flush: loads a bubble. ex_valid=0, reg_write/mem_read/mem_write=0, all data fields 0, f=000.
- hold: every field keeps its value. Forwarding still re-evaluates combinationally each cycle.
- load_use_stall: loads a bubble and upstream holds. The stall is asserted combinationally when all of the following are true:
  - ex_valid and ex_mem_read are set;
  - ex_rd≠0;
  - ex_rd equals id_rs1, or equals id_rs2 when the instruction uses rs2 (id_alu_src=0 or id_mem_write);
  - id_valid is set.
- load_use_stall is forced to 0 while hold or flush is asserted.
- Normal load: every field is captured from the id_* inputs. Control bits are ANDed with id_valid.
- Forwarding (combinational, on registered rs1/rs2):
  - Source is EX/MEM if exmem_reg_write, exmem_rd≠0 and exmem_rd==rs.
  - Otherwise MEM/WB under the same conditions on memwb_*.
  - Otherwise the registered file data.
  - EX/MEM has priority when both match.
  - x0 is never forwarded.
- oporand1 is forwarded rs1.
- oporand2 is id_imm_q when alu_src_q, otherwise forwarded rs2.
- ex_store_data is always forwarded rs2, regardless of alu_src.
- f is alu_f_q, passed through unchanged. Valid codes: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt. Other codes pass through; the ALU yields 0 for them.

## Timing
- Latency: id_* is sampled at edge N and appears on the outputs after edge N.
- The forwarding path is zero-cycle combinational from the exmem_*/memwb_* inputs to the operands.
- load_use_stall is combinational from id_* and the registered state. It is valid in the same cycle and deasserts after the bubble is loaded.
- Simultaneous flush and hold: flush wins and a bubble is loaded.
- rst mid-hold clears the stage on the next edge.

## Structure
- Shared package alu_pkg holds the ALU_ADD/SUB/AND/OR/XOR/SLT 3-bit localparams and the XLEN/REGW defaults.
- One sub-module, forwarding_unit: a purely combinational rs-index comparator and mux select. It is instantiated twice, once for rs1 and once for rs2.

## Test plan
- Normal load: rs1_data=5, rs2_data=3, f=001, alu_src=0 -> one cycle later oporand1=5, oporand2=3, f=001, ex_valid=1.
- Forwarding priority: rs1=7 held in EX; exmem_rd=7 with result 0xAA and memwb_rd=7 with data 0xBB -> oporand1=0xAA. Drop exmem_reg_write -> 0xBB. Set rd=0 on both -> register-file value.
- Immediate path: alu_src=1, imm=0xFFFFFFFC, rs2 forwarded 9 -> oporand2=0xFFFFFFFC, ex_store_data=9.
- Load-use: EX holds a load with rd=4 and ID reads rs2=4 -> load_use_stall=1 in that cycle; next cycle ex_valid=0 and ex_reg_write=0, and load_use_stall=0.
- Hold/flush: hold for 3 cycles -> outputs stable. Flush together with hold -> bubble. rst asserted during hold -> all outputs 0 after the next edge.
